mor1kx_csaw_shadow_stack: RTL and testbench
===========================================

Name: mor1kx_csaw_shadow_stack

Overview:
Hardware shadow return-address stack that consumes the CSAW r9 (link register) tap from the register-file RAM. On every call it pushes the link value the register file captured. On every `l.jr r9` return it pops and compares the popped entry with the jump target. A mismatch raises a sticky alarm toward the CSAW monitor.

Parameters:
- DEPTH_LOG2, 4, log2 of stack entries (16 by default).
- DATA_WIDTH, 32, link/target address width; matches the register-file data width.
- ALARM_ON_UNDERFLOW, 0, when 1 a return on an empty stack also raises the alarm.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- enable_i  in  1  when 0, call_i and ret_i are ignored; state and flags are held.
- call_i  in  1  pulse; this cycle the register file writes r9 with a call link value (jal/jalr retire).
- r9_i  in  DATA_WIDTH  registered r9 tap from the register file; valid the cycle after the write.
- ret_i  in  1  pulse; an `l.jr r9` return retires this cycle.
- ret_target_i  in  DATA_WIDTH  jump target of that return.
- clear_i  in  1  clears alarm_o, overflow_o and underflow_o; stack contents are kept.
- alarm_o  out  1  sticky mismatch (or underflow) alarm.
- mismatch_o  out  1  one-cycle pulse per failed compare.
- overflow_o  out  1  sticky; a push happened while the stack was full.
- underflow_o  out  1  sticky; a return happened while the stack was empty.
- depth_o  out  DEPTH_LOG2+1  current entry count, 0..2^DEPTH_LOG2.
- tos_o  out  DATA_WIDTH  top-of-stack value; 0 when empty.

Behaviour:
- Reset (rst_n=0 at a clk edge): sp=0, count=0, state=IDLE, every output 0. Memory contents are don't-care.
- Storage is a circular buffer of 2^DEPTH_LOG2 entries with write pointer sp. Push writes mem[sp] and increments sp mod depth. Pop decrements sp mod depth.
- State machine:
  - IDLE: call_i=1 moves to PUSH_PEND. There is no push yet, because r9_i is still stale.
  - PUSH_PEND: lasts exactly one cycle. r9_i is pushed at the end of the cycle, then the state returns to IDLE. A call_i arriving in the same cycle stays in PUSH_PEND and schedules another push next cycle, giving back-to-back calls one push each.
- Return in IDLE, count>0: compare ret_target_i with mem[sp-1] and pop.
  - Unequal: mismatch_o=1 on the next cycle for one cycle, and alarm_o sets on the next cycle.
  - The pop happens whether or not the compare matches.
- Return in IDLE, count=0: no compare, no pop. underflow_o sets next cycle. alarm_o also sets if ALARM_ON_UNDERFLOW=1.
- Return in PUSH_PEND (the call had no intervening instruction): compare ret_target_i against r9_i (bypass). The pending push is cancelled, so count and sp are unchanged.
- call_i and ret_i in the same cycle: the return is processed first against the current top of stack, then the call goes to PUSH_PEND.
- Full stack with a push: the oldest entry is overwritten through the wrap, count saturates at 2^DEPTH_LOG2, and overflow_o sets. Later pops below the lost region appear as underflow, not mismatch.
- clear_i has priority over setting a flag in the same cycle: the flags are 0 next cycle. A mismatch_o pulse still fires.
- enable_i=0: events are ignored. A PUSH_PEND already entered still completes.
- Latency:
  - call_i to depth_o increment: 2 cycles.
  - ret_i to mismatch_o/alarm_o/depth_o decrement: 1 cycle.
- Reset mid-operation, including during PUSH_PEND, drops the pending push and empties the stack.

Test Plan:
- Call with r9_i=0x0000_1004 one cycle after call_i, then ret_i with target 0x0000_1004 -> depth_o goes 0→1→0; mismatch_o and alarm_o stay 0.
- Push 0x100 then ret_i with target 0x200 -> mismatch_o pulses once and alarm_o=1 until clear_i, after which alarm_o=0 and depth_o=0.
- 17 calls with values 0x10..0x20 (DEPTH_LOG2=4) -> overflow_o=1 and depth_o=16. Sixteen correct returns of 0x20 down to 0x11 give no mismatch, and a 17th return sets underflow_o=1.
- ret_i on an empty stack with ALARM_ON_UNDERFLOW=0 -> underflow_o=1, alarm_o=0. Repeat with parameter =1 -> alarm_o=1.
- call_i then ret_i in PUSH_PEND with target equal to r9_i=0x2A0 -> no mismatch and depth_o stays 0. With target 0x2A4 -> mismatch_o pulses.
- Assert rst_n=0 during PUSH_PEND with depth 3 -> next cycle all outputs are 0, and the first subsequent return flags underflow.

Source files
------------

// File: rtl/mor1kx_csaw_shadow_stack.sv
// Shadow return-address stack fed by the r9 register-file tap.
// Calls push the captured link value; l.jr r9 returns pop and compare, and a mismatch raises a sticky alarm.
module mor1kx_csaw_shadow_stack #(
  parameter int DEPTH_LOG2         = 4,
  parameter int DATA_WIDTH         = 32,
  parameter bit ALARM_ON_UNDERFLOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  call_i,
  input  logic [DATA_WIDTH-1:0] r9_i,
  input  logic                  ret_i,
  input  logic [DATA_WIDTH-1:0] ret_target_i,
  input  logic                  clear_i,
  output logic                  alarm_o,
  output logic                  mismatch_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [DEPTH_LOG2:0]   depth_o,
  output logic [DATA_WIDTH-1:0] tos_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, PUSH_PEND} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   sp, sp_m1;
  logic [DEPTH_LOG2:0]     count;
  logic                    call_v, ret_v, full, empty;
  logic                    do_push, do_pop, do_cmp, under, mis_nxt;
  logic [DATA_WIDTH-1:0]   cmp_val;

  assign call_v = enable_i & call_i;
  assign ret_v  = enable_i & ret_i;
  assign sp_m1  = sp - 1'b1;
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A call in either state (re)arms the push for next cycle, when r9_i is fresh.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:      if (call_v) state_nxt = PUSH_PEND;
      PUSH_PEND: if (call_v) state_nxt = PUSH_PEND;
      default:   state_nxt = IDLE;
    endcase
  end

  // The pending push still completes with enable low; a return in PUSH_PEND
  // matches against the bypassed r9 and cancels that push.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_cmp  = 1'b0;
    under   = 1'b0;
    cmp_val = '0;
    case (state)
      IDLE: if (ret_v) begin
        if (!empty) begin
          do_cmp  = 1'b1;
          do_pop  = 1'b1;
          cmp_val = mem[sp_m1];
        end else begin
          under = 1'b1;
        end
      end
      PUSH_PEND: begin
        if (ret_v) begin
          do_cmp  = 1'b1;
          cmp_val = r9_i;
        end else begin
          do_push = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mis_nxt = do_cmp && (cmp_val != ret_target_i);

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[sp] <= r9_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp          <= '0;
      count       <= '0;
      mismatch_o  <= 1'b0;
      alarm_o     <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      // A full push overwrites the oldest entry through the wrap.
      if (do_push) begin
        sp <= sp + 1'b1;
        if (!full) count <= count + 1'b1;
      end else if (do_pop) begin
        sp    <= sp_m1;
        count <= count - 1'b1;
      end
      mismatch_o <= mis_nxt;
      if (clear_i) begin
        alarm_o     <= 1'b0;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
      end else begin
        if (mis_nxt)          alarm_o     <= 1'b1;
        if (do_push && full)  overflow_o  <= 1'b1;
        if (under) begin
          underflow_o <= 1'b1;
          if (ALARM_ON_UNDERFLOW) alarm_o <= 1'b1;
        end
      end
    end
  end

  assign depth_o = count;
  assign tos_o   = empty ? '0 : mem[sp_m1];

endmodule

// File: tb/tb_mor1kx_csaw_shadow_stack.sv
// Directed bench for the shadow stack; two instances differ only in ALARM_ON_UNDERFLOW.
module tb_mor1kx_csaw_shadow_stack;
  localparam int DW = 32;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst_n, enable_i, call_i, ret_i, clear_i;
  logic [DW-1:0] r9_i, ret_target_i;
  logic          alarm, mismatch, overflow, underflow;
  logic [DL:0]   depth;
  logic [DW-1:0] tos;
  logic          alarm1, mismatch1, overflow1, underflow1;
  logic [DL:0]   depth1;
  logic [DW-1:0] tos1;
  int            n_chk = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  mor1kx_csaw_shadow_stack #(.DEPTH_LOG2(DL), .DATA_WIDTH(DW), .ALARM_ON_UNDERFLOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .call_i(call_i), .r9_i(r9_i),
    .ret_i(ret_i), .ret_target_i(ret_target_i), .clear_i(clear_i),
    .alarm_o(alarm), .mismatch_o(mismatch), .overflow_o(overflow),
    .underflow_o(underflow), .depth_o(depth), .tos_o(tos));

  mor1kx_csaw_shadow_stack #(.DEPTH_LOG2(DL), .DATA_WIDTH(DW), .ALARM_ON_UNDERFLOW(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .call_i(call_i), .r9_i(r9_i),
    .ret_i(ret_i), .ret_target_i(ret_target_i), .clear_i(clear_i),
    .alarm_o(alarm1), .mismatch_o(mismatch1), .overflow_o(overflow1),
    .underflow_o(underflow1), .depth_o(depth1), .tos_o(tos1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [DW-1:0] v);
    call_i = 1'b1; tick();
    call_i = 1'b0; r9_i = v; tick();
  endtask

  task automatic do_ret(input logic [DW-1:0] t);
    ret_i = 1'b1; ret_target_i = t; tick();
    ret_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1; tick();
    clear_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable_i = 1'b1; call_i = 1'b0; ret_i = 1'b0; clear_i = 1'b0;
    r9_i = '0; ret_target_i = '0;
    tick(); tick();
    chk("rst_depth", depth, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_mis", mismatch, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_tos", tos, 0);
    rst_n = 1'b1;

    // matched call/return, including the 2-cycle push latency
    call_i = 1'b1; tick();
    call_i = 1'b0; r9_i = 32'h1004;
    chk("lat_depth0", depth, 0);
    tick();
    chk("call_depth", depth, 1);
    chk("call_tos", tos, 32'h1004);
    do_ret(32'h1004);
    chk("ret_mis", mismatch, 0);
    chk("ret_alarm", alarm, 0);
    chk("ret_depth", depth, 0);

    // mismatching return
    do_call(32'h100);
    do_ret(32'h200);
    chk("bad_mis", mismatch, 1);
    chk("bad_alarm", alarm, 1);
    chk("bad_depth", depth, 0);
    tick();
    chk("bad_mis_pulse", mismatch, 0);
    chk("bad_alarm_sticky", alarm, 1);
    do_clear();
    chk("clr_alarm", alarm, 0);
    chk("clr_depth", depth, 0);

    // overflow by 17 pushes, then 16 matching pops and one underflow
    for (int i = 0; i < 17; i++) do_call(32'h10 + i);
    chk("ovf_flag", overflow, 1);
    chk("ovf_depth", depth, 16);
    chk("ovf_tos", tos, 32'h20);
    for (int i = 0; i < 16; i++) begin
      do_ret(32'h20 - i);
      chk($sformatf("pop%0d_mis", i), mismatch, 0);
    end
    chk("pop_depth", depth, 0);
    chk("pop_alarm", alarm, 0);
    chk("pop_unf0", underflow, 0);
    do_ret(32'h10);
    chk("unf_flag", underflow, 1);
    chk("unf_mis", mismatch, 0);
    chk("unf_alarm_p0", alarm, 0);
    chk("unf_alarm_p1", alarm1, 1);
    do_clear();
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);

    // return while the push is pending: bypass against r9_i
    call_i = 1'b1; tick();
    call_i = 1'b0; r9_i = 32'h2A0; ret_i = 1'b1; ret_target_i = 32'h2A0; tick();
    ret_i = 1'b0;
    chk("byp_ok_mis", mismatch, 0);
    chk("byp_ok_depth", depth, 0);
    tick();
    chk("byp_ok_depth2", depth, 0);
    call_i = 1'b1; tick();
    call_i = 1'b0; r9_i = 32'h2A0; ret_i = 1'b1; ret_target_i = 32'h2A4; tick();
    ret_i = 1'b0;
    chk("byp_bad_mis", mismatch, 1);
    chk("byp_bad_depth", depth, 0);
    do_clear();

    // call and return together in IDLE: return first, then push
    do_call(32'h50);
    call_i = 1'b1; ret_i = 1'b1; ret_target_i = 32'h50; tick();
    call_i = 1'b0; ret_i = 1'b0; r9_i = 32'h60;
    chk("cr_mis", mismatch, 0);
    chk("cr_depth0", depth, 0);
    tick();
    chk("cr_depth1", depth, 1);
    chk("cr_tos", tos, 32'h60);

    // disabled events are ignored
    enable_i = 1'b0;
    call_i = 1'b1; tick(); call_i = 1'b0; tick();
    do_ret(32'hDEAD);
    chk("dis_depth", depth, 1);
    chk("dis_mis", mismatch, 0);
    enable_i = 1'b1;
    do_ret(32'h60);

    // reset during PUSH_PEND at depth 3
    do_call(32'h1); do_call(32'h2); do_call(32'h3);
    chk("pre_rst_depth", depth, 3);
    call_i = 1'b1; tick();
    call_i = 1'b0; r9_i = 32'h44; rst_n = 1'b0; tick();
    chk("mrst_depth", depth, 0);
    chk("mrst_tos", tos, 0);
    chk("mrst_alarm", alarm, 0);
    rst_n = 1'b1; tick();
    chk("mrst_nopush", depth, 0);
    do_ret(32'h3);
    chk("mrst_unf", underflow, 1);
    chk("mrst_unf_mis", mismatch, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
